// File: rtl/usb_bus_arbiter.sv
// usb_bus_arbiter: shares one 8-bit register bus between M0 (usb_driver host
// bridge) and M1 (CPU debug/monitor port). Round-robin, one transaction per
// grant, registered strobes, ack completion with a timeout error path.
// Optional feature macro: ARB_LOCK_EN (lock keeps the grant for the next
// transaction, with a starvation guard after 4 consecutive transactions).
module usb_bus_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m0_read,
  input  logic              m1_read,
  input  logic              m0_write,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m0_lock,
  input  logic              m1_lock,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_done,
  output logic              m1_done,
  output logic              m0_err,
  output logic              m1_err,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_read,
  output logic              bus_write,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack
);

  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE,
    S_GRANT_AGAIN
  } state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;           // 0 = M0, 1 = M1
  logic              last_owner_q, last_owner_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic              bus_read_q, bus_read_d;
  logic              bus_write_q, bus_write_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
  logic              err_q, err_d;

  logic              launch;
  logic              launch_owner;
  logic              sel_read;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_illegal;

`ifdef ARB_LOCK_EN
  logic [2:0]        starve_q, starve_d;
  logic [2:0]        waited;
  logic              own_req;
  logic              own_lock;
  logic              other_req;

  assign own_req   = owner_q ? m1_req  : m0_req;
  assign own_lock  = owner_q ? m1_lock : m0_lock;
  assign other_req = owner_q ? m0_req  : m1_req;
`else
  logic              unused_lock;
  assign unused_lock = m0_lock ^ m1_lock;
`endif

  // Decide whether a transaction launches this cycle and for which master
  always_comb begin
    launch       = 1'b0;
    launch_owner = owner_q;
    case (state_q)
      S_IDLE: begin
        if (m0_req || m1_req) begin
          launch       = 1'b1;
          // Single requester wins outright; on a tie the non-last owner wins
          launch_owner = (m0_req && m1_req) ? ~last_owner_q : m1_req;
        end
      end
      S_GRANT_AGAIN: launch = 1'b1;
      default: ;
    endcase
  end

  assign sel_read    = launch_owner ? m1_read  : m0_read;
  assign sel_write   = launch_owner ? m1_write : m0_write;
  assign sel_addr    = launch_owner ? m1_addr  : m0_addr;
  assign sel_wdata   = launch_owner ? m1_wdata : m0_wdata;
  assign sel_illegal = (sel_read == sel_write);

  // Next-state, strobe, timer and completion logic
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    timer_d      = timer_q;
    bus_addr_d   = bus_addr_q;
    bus_read_d   = bus_read_q;
    bus_write_d  = bus_write_q;
    bus_wdata_d  = bus_wdata_q;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
    err_d        = err_q;
`ifdef ARB_LOCK_EN
    starve_d     = starve_q;
    waited       = 3'd0;
`endif

    case (state_q)
      S_BUSY: begin
        if (bus_ack) begin
          // Ack beats a coincident timeout
          if (bus_read_q) begin
            if (owner_q) m1_rdata_d = bus_rdata;
            else         m0_rdata_d = bus_rdata;
          end
          err_d       = 1'b0;
          bus_read_d  = 1'b0;
          bus_write_d = 1'b0;
          state_d     = S_DONE;
        end else if (timer_q == TMR_LAST) begin
          if (bus_read_q) begin
            if (owner_q) m1_rdata_d = '1;
            else         m0_rdata_d = '1;
          end
          err_d       = 1'b1;
          bus_read_d  = 1'b0;
          bus_write_d = 1'b0;
          state_d     = S_DONE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_DONE: begin
        last_owner_d = owner_q;
        err_d        = 1'b0;
        state_d      = S_IDLE;
`ifdef ARB_LOCK_EN
        // Count how many transactions in a row the other master sat out
        waited = other_req ? (starve_q + 3'd1) : 3'd0;
        if (own_lock && own_req && (waited < 3'd4)) begin
          state_d  = S_GRANT_AGAIN;
          starve_d = waited;
        end else begin
          starve_d = 3'd0;
        end
`endif
      end
      default: ;
    endcase

    if (launch) begin
      owner_d     = launch_owner;
      bus_addr_d  = sel_addr;
      bus_wdata_d = sel_wdata;
      timer_d     = '0;
      // Illegal requests still get a grant but never drive a strobe
      bus_read_d  = sel_read  & ~sel_write;
      bus_write_d = sel_write & ~sel_read;
      err_d       = sel_illegal;
      state_d     = sel_illegal ? S_DONE : S_BUSY;
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      timer_q      <= '0;
      bus_addr_q   <= '0;
      bus_read_q   <= 1'b0;
      bus_write_q  <= 1'b0;
      bus_wdata_q  <= '0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
      err_q        <= 1'b0;
`ifdef ARB_LOCK_EN
      starve_q     <= 3'd0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      timer_q      <= timer_d;
      bus_addr_q   <= bus_addr_d;
      bus_read_q   <= bus_read_d;
      bus_write_q  <= bus_write_d;
      bus_wdata_q  <= bus_wdata_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
      err_q        <= err_d;
`ifdef ARB_LOCK_EN
      starve_q     <= starve_d;
`endif
    end
  end

  assign m0_gnt    = (state_q != S_IDLE) && !owner_q;
  assign m1_gnt    = (state_q != S_IDLE) &&  owner_q;
  assign m0_done   = (state_q == S_DONE) && !owner_q;
  assign m1_done   = (state_q == S_DONE) &&  owner_q;
  assign m0_err    = m0_done && err_q;
  assign m1_err    = m1_done && err_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign bus_addr  = bus_addr_q;
  assign bus_read  = bus_read_q;
  assign bus_write = bus_write_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_usb_bus_arbiter.sv
// Directed bench for usb_bus_arbiter (default TIMEOUT=16).
module tb_usb_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       m0_req = 1'b0, m1_req = 1'b0;
  logic [7:0] m0_addr = '0, m1_addr = '0;
  logic       m0_read = 1'b0, m1_read = 1'b0;
  logic       m0_write = 1'b0, m1_write = 1'b0;
  logic [7:0] m0_wdata = '0, m1_wdata = '0;
  logic       m0_lock = 1'b0, m1_lock = 1'b0;
  logic       m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err;
  logic [7:0] m0_rdata, m1_rdata;
  logic [7:0] bus_addr, bus_wdata;
  logic       bus_read, bus_write;
  logic [7:0] bus_rdata = '0;
  logic       bus_ack = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  usb_bus_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m1_req(m1_req),
    .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_read(m0_read), .m1_read(m1_read),
    .m0_write(m0_write), .m1_write(m1_write),
    .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_lock(m0_lock), .m1_lock(m1_lock),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_done(m0_done), .m1_done(m1_done),
    .m0_err(m0_err), .m1_err(m1_err),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .bus_addr(bus_addr), .bus_read(bus_read), .bus_write(bus_write),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m0(input logic req, input logic rd, input logic wr,
                          input logic [7:0] addr, input logic [7:0] wdata);
    m0_req = req; m0_read = rd; m0_write = wr; m0_addr = addr; m0_wdata = wdata;
  endtask

  task automatic drive_m1(input logic req, input logic rd, input logic wr,
                          input logic [7:0] addr, input logic [7:0] wdata);
    m1_req = req; m1_read = rd; m1_write = wr; m1_addr = addr; m1_wdata = wdata;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic exp1;
    logic [4:0] exp_own;

    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    check_val("rst_gnt", 32'({m0_gnt, m1_gnt}), 32'h0);
    check_val("rst_done_err", 32'({m0_done, m1_done, m0_err, m1_err}), 32'h0);
    check_val("rst_strobes", 32'({bus_read, bus_write}), 32'h0);
    check_val("rst_addr", 32'(bus_addr), 32'h0);
    check_val("rst_wdata", 32'(bus_wdata), 32'h0);
    check_val("rst_rdata", 32'({m0_rdata, m1_rdata}), 32'h0);
    rst_n = 1'b1;

    // Single write from M0, ack two cycles after the strobe
    drive_m0(1'b1, 1'b0, 1'b1, 8'h12, 8'h6A);
    tick();
    check_val("wr_gnt", 32'({m0_gnt, m1_gnt}), 32'h2);
    check_val("wr_strobes", 32'({bus_read, bus_write}), 32'h1);
    check_val("wr_addr", 32'(bus_addr), 32'h12);
    check_val("wr_wdata", 32'(bus_wdata), 32'h6A);
    tick();
    check_val("wr_hold", 32'({bus_write, m0_done}), 32'h2);
    bus_ack = 1'b1;
    tick();
    check_val("wr_done", 32'({m0_gnt, m0_done, m0_err, bus_write}), 32'hC);
    check_val("wr_m1_quiet", 32'({m1_gnt, m1_done, m1_err, m1_rdata}), 32'h0);
    drive_m0(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    bus_ack = 1'b0;
    tick();
    check_val("wr_idle", 32'({m0_gnt, m0_done}), 32'h0);

    // Single read from M1
    drive_m1(1'b1, 1'b1, 1'b0, 8'h05, 8'h00);
    tick();
    check_val("rd_gnt", 32'({m0_gnt, m1_gnt}), 32'h1);
    check_val("rd_strobes", 32'({bus_read, bus_write}), 32'h2);
    check_val("rd_addr", 32'(bus_addr), 32'h05);
    bus_ack = 1'b1;
    bus_rdata = 8'hA5;
    tick();
    check_val("rd_done", 32'({m1_done, m1_err, bus_read}), 32'h4);
    check_val("rd_rdata", 32'(m1_rdata), 32'hA5);
    drive_m1(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    bus_ack = 1'b0;
    bus_rdata = 8'h00;
    tick();
    check_val("rd_after", 32'({m1_done, m1_rdata}), 32'h0A5);

    // Ack outside BUSY must have no effect
    bus_ack = 1'b1;
    tick();
    check_val("stray_ack", 32'({m0_gnt, m1_gnt, m0_done, m1_done}), 32'h0);
    bus_ack = 1'b0;

    // Contention after reset: M0 first, then alternating
    do_reset();
    drive_m0(1'b1, 1'b0, 1'b1, 8'h20, 8'h55);
    drive_m1(1'b1, 1'b1, 1'b0, 8'h30, 8'h00);
    for (int i = 0; i < 4; i++) begin
      exp1 = (i % 2) == 1;
      tick();
      check_val($sformatf("rr_gnt%0d", i), 32'({m0_gnt, m1_gnt}), exp1 ? 32'h1 : 32'h2);
      check_val($sformatf("rr_excl%0d", i), 32'({bus_read & bus_write, m0_gnt & m1_gnt}), 32'h0);
      check_val($sformatf("rr_addr%0d", i), 32'(bus_addr), exp1 ? 32'h30 : 32'h20);
      bus_ack = 1'b1;
      bus_rdata = 8'h40 + 8'(i);
      tick();
      check_val($sformatf("rr_done%0d", i), 32'({m0_done, m1_done}), exp1 ? 32'h1 : 32'h2);
      if (exp1) check_val($sformatf("rr_rdata%0d", i), 32'(m1_rdata), 32'h40 + 32'(i));
      bus_ack = 1'b0;
      tick();
    end
    drive_m0(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive_m1(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();

    // Timeout on an unacknowledged M0 read
    drive_m0(1'b1, 1'b1, 1'b0, 8'h44, 8'h00);
    tick();
    cnt = bus_read ? 1 : 0;
    for (int k = 0; k < 40; k++) begin
      if (!bus_read) break;
      tick();
      if (bus_read) cnt++;
    end
    check_val("to_strobe_len", 32'(cnt), 32'd16);
    check_val("to_done_err", 32'({m0_done, m0_err}), 32'h3);
    check_val("to_rdata", 32'(m0_rdata), 32'hFF);
    drive_m0(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    check_val("to_idle", 32'({m0_done, m0_err, m0_gnt}), 32'h0);
    drive_m0(1'b1, 1'b0, 1'b1, 8'h45, 8'h11);
    tick();
    check_val("to_next_wr", 32'({bus_write, bus_addr}), 32'h145);
    bus_ack = 1'b1;
    tick();
    check_val("to_next_done", 32'({m0_done, m0_err, m0_rdata}), 32'h2FF);
    bus_ack = 1'b0;
    drive_m0(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();

    // Illegal request: read and write together
    drive_m1(1'b1, 1'b1, 1'b1, 8'h07, 8'h00);
    tick();
    check_val("ill_done", 32'({m1_gnt, m1_done, m1_err}), 32'h7);
    check_val("ill_strobes", 32'({bus_read, bus_write}), 32'h0);
    drive_m1(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    check_val("ill_idle", 32'({m1_gnt, m1_done, m1_err}), 32'h0);

    // Reset in the middle of a transaction
    drive_m0(1'b1, 1'b0, 1'b1, 8'h50, 8'h22);
    tick();
    check_val("ab_busy", 32'({m0_gnt, bus_write}), 32'h3);
    rst_n = 1'b0;
    tick();
    check_val("ab_ctrl", 32'({m0_gnt, m1_gnt, m0_done, m1_done, bus_read, bus_write}), 32'h0);
    check_val("ab_data", 32'({bus_addr, bus_wdata, m0_rdata, m1_rdata}), 32'h0);
    drive_m0(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    rst_n = 1'b1;
    tick();
    check_val("ab_no_done", 32'({m0_done, m1_done, m0_gnt}), 32'h0);

    // M0 holds lock while M1 waits
`ifdef ARB_LOCK_EN
    exp_own = 5'b10000;
`else
    exp_own = 5'b01010;
`endif
    do_reset();
    m0_lock = 1'b1;
    drive_m0(1'b1, 1'b0, 1'b1, 8'h21, 8'h01);
    drive_m1(1'b1, 1'b0, 1'b1, 8'h31, 8'h02);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val($sformatf("lk_gnt%0d", i), 32'({m0_gnt, m1_gnt}), exp_own[i] ? 32'h1 : 32'h2);
      bus_ack = 1'b1;
      tick();
      bus_ack = 1'b0;
      tick();
    end
    drive_m0(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive_m1(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    m0_lock = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
